cnn_result_streamer: RTL and testbench

- Companion to the time-multiplexed 4x4 CNN array. The array sweeps all 16 cells in 16 clocks and presents the cell states Y1..Y16 in parallel.
- This block tracks the array's sweep phase and counts a programmed number of sweeps (iterations).
- After the last sweep it snapshots all 16 cell states and streams them out one per beat over a valid/ready interface, with a binarised (sign) output per cell.
- It sits between the array and the host/readback logic.

---
 rtl/cnn_result_streamer.sv | 156 +++++++++++++++
 tb/tb_cnn_result_streamer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_result_streamer.sv
// Result streamer for the time-multiplexed 4x4 CNN array.
// Follows the array's sweep phase and counts the programmed sweeps. After the
// last sweep it takes one snapshot of all cell states and streams the cells
// out one per beat over valid/ready, with a sign bit per cell.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | tracking sweep phase, counting sweeps, waiting for capture phase
// SEND  | streaming the 16 snapshot words, one per accepted beat
// DONE  | one-cycle done pulse, then back to IDLE
module cnn_result_streamer #(
    parameter int WIDTH         = 9,
    parameter int CELLS         = 16,
    parameter int ITER_W        = 8,
    parameter int CAPTURE_PHASE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ITER_W-1:0]         iterations,
    input  logic [CELLS*2*WIDTH-1:0]  y_in,
    output logic [2*WIDTH-1:0]        out_data,
    output logic                      out_bin,
    output logic [3:0]                out_index,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int DW = 2 * WIDTH;
    localparam logic [3:0] CAP_PHASE = 4'(CAPTURE_PHASE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        phase_q;
    logic [ITER_W-1:0] sweeps_q;
    logic [3:0]        index_q;
    logic [DW-1:0]     snap_q [CELLS];

    logic capture;
    logic xfer;

    // The final sweep has completed and the array has reached the capture phase.
    assign capture = (state_q == RUN) && (sweeps_q == '0) && (phase_q == CAP_PHASE);
    assign xfer    = (state_q == SEND) && out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (capture) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (index_q == 4'd15);
                if (xfer && (index_q == 4'd15)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase, sweep and beat-index counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 4'd0;
            sweeps_q <= '0;
            index_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // start coincides with array phase 0, so next phase is 1.
                        phase_q  <= 4'd1;
                        sweeps_q <= (iterations == '0) ? ITER_W'(1) : iterations;
                    end
                end
                RUN: begin
                    phase_q <= phase_q + 4'd1;
                    if ((phase_q == 4'd15) && (sweeps_q != '0)) begin
                        sweeps_q <= sweeps_q - ITER_W'(1);
                    end
                    if (capture) begin
                        index_q <= 4'd0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        index_q <= index_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Snapshot of all cell states, written only on the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CELLS; k++) begin
                snap_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < CELLS; k++) begin
                snap_q[k] <= y_in[k*DW +: DW];
            end
        end
    end

    // Beat data path: direct view of the selected snapshot word.
    always_comb begin
        out_data  = snap_q[index_q];
        out_bin   = ~out_data[DW-1];
        out_index = index_q;
    end

endmodule

// File: tb/tb_cnn_result_streamer.sv
// Self-checking bench for cnn_result_streamer: table of frames plus hand
// sequences for reset abort; beats checked against a scoreboard queue.
module tb_cnn_result_streamer;

    localparam int W  = 9;
    localparam int DW = 18;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         iterations;
    logic [16*DW-1:0]   y_in;
    logic [DW-1:0]      out_data;
    logic               out_bin;
    logic [3:0]         out_index;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               busy;
    logic               done;

    cnn_result_streamer #(.WIDTH(W), .CELLS(16), .ITER_W(8), .CAPTURE_PHASE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .iterations(iterations), .y_in(y_in),
        .out_data(out_data), .out_bin(out_bin), .out_index(out_index),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          bin;
        logic [3:0]    index;
        logic          last;
    } beat_t;

    typedef struct {
        logic [7:0] iters;
        int         pat_mode;
        int         ready_mode;
        int         exp_lat;
        bit         start_run;
        bit         start_done;
    } vec_t;

    beat_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    int            xfers = 0;
    int            done_cnt = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] stall_data;
    logic [3:0]    stall_idx;
    logic [DW-1:0] pat [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16*DW-1:0] rnd_y();
        logic [16*DW-1:0] v;
        for (int k = 0; k < 16; k++) v[k*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [16*DW-1:0] pack_pat();
        logic [16*DW-1:0] v;
        for (int k = 0; k < 16; k++) v[k*DW +: DW] = pat[k];
        return v;
    endfunction

    task automatic build_pat(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       pat[k] = DW'((k + 1) * 100);
                1:       pat[k] = DW'($urandom);
                2:       pat[k] = (k % 2 == 0) ? 18'h00000 : 18'h20000;
                default: pat[k] = 18'h3FFFF;
            endcase
        end
    endtask

    // Beat monitor, sampled on the falling edge, between driven inputs and the next rising edge.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (out_valid) begin
                if (stalled) begin
                    chk("stall_data", 32'(out_data), 32'(stall_data));
                    chk("stall_index", 32'(out_index), 32'(stall_idx));
                end
                if (out_ready) begin
                    stalled = 1'b0;
                    xfers++;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 32'(out_index), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", 32'(out_data), 32'(e.data));
                        chk("beat_bin", 32'(out_bin), 32'(e.bin));
                        chk("beat_index", 32'(out_index), 32'(e.index));
                        chk("beat_last", 32'(out_last), 32'(e.last));
                    end
                end else begin
                    stalled    = 1'b1;
                    stall_data = out_data;
                    stall_idx  = out_index;
                end
            end
            if (done) done_cnt++;
        end
    end

    // Starts a frame and waits for the first valid beat; drives random y_in
    // except on the expected capture edge, where the pattern is applied.
    task automatic wait_valid(input logic [7:0] it, input int mode, input int exp_lat, input bit start_run);
        int cnt;
        beat_t e;
        build_pat(mode);
        xfers      = 0;
        stalled    = 1'b0;
        out_ready  = 1'b0;
        iterations = it;
        start      = 1'b1;
        y_in       = rnd_y();
        @(posedge clk); #1;
        start = 1'b0;
        cnt   = 1;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!out_valid && cnt < exp_lat + 40) begin
            start = (start_run && cnt == 3);
            if (cnt + 1 == exp_lat) begin
                y_in = pack_pat();
                for (int k = 0; k < 16; k++) begin
                    e.data  = pat[k];
                    e.bin   = ($signed(pat[k]) >= 0);
                    e.index = 4'(k);
                    e.last  = (k == 15);
                    sb.push_back(e);
                end
            end else begin
                y_in = rnd_y();
            end
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        chk("first_valid_latency", 32'(cnt), 32'(exp_lat));
        chk("valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input int ready_mode, input bit start_done);
        int n;
        int d0;
        d0 = done_cnt;
        n  = 0;
        while (!done && n < 300) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 3 == 0);
                default: out_ready = 1'($urandom);
            endcase
            y_in = rnd_y();
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (ready_mode == 0) chk("drain_cycles", 32'(n), 32'd16);
        chk("transfers", 32'(xfers), 32'd16);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("valid_in_done", 32'(out_valid), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        start = start_done;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("still_idle", 32'(busy), 32'd0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("no_second_frame", 32'(out_valid), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{iters: 8'd1,   pat_mode: 0, ready_mode: 0, exp_lat: 18,   start_run: 1'b0, start_done: 1'b0};
        vecs[1] = '{iters: 8'd3,   pat_mode: 3, ready_mode: 0, exp_lat: 50,   start_run: 1'b0, start_done: 1'b0};
        vecs[2] = '{iters: 8'd2,   pat_mode: 1, ready_mode: 1, exp_lat: 34,   start_run: 1'b0, start_done: 1'b0};
        vecs[3] = '{iters: 8'd0,   pat_mode: 0, ready_mode: 0, exp_lat: 18,   start_run: 1'b1, start_done: 1'b1};
        vecs[4] = '{iters: 8'd1,   pat_mode: 2, ready_mode: 2, exp_lat: 18,   start_run: 1'b0, start_done: 1'b0};
        vecs[5] = '{iters: 8'd255, pat_mode: 1, ready_mode: 0, exp_lat: 4082, start_run: 1'b0, start_done: 1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        iterations = 8'd0;
        y_in       = '0;
        out_ready  = 1'b0;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_bin", 32'(out_bin), 32'd1);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Abort in SEND at index 7.
        wait_valid(8'd1, 0, 18, 1'b0);
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("abort_index", 32'(out_index), 32'd7);
        chk("abort_valid_before", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_index_rst", 32'(out_index), 32'd0);
        chk("abort_data_rst", 32'(out_data), 32'd0);
        chk("abort_bin_rst", 32'(out_bin), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            wait_valid(vecs[i].iters, vecs[i].pat_mode, vecs[i].exp_lat, vecs[i].start_run);
            drain(vecs[i].ready_mode, vecs[i].start_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
